// File: rtl/down_timer_pkg.sv
// down_timer_pkg: shared constants for the loadable down-counting timer.
//   ST_IDLE / ST_RUN : state encoding (legacy-compatible localparams)
package down_timer_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage : down_timer_pkg

// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with terminal-count pulse and optional auto-reload.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   load         strobe; capture load_value into count and reload register
//   load_value   start/reload value N (0 parks the timer in IDLE)
//   enable       decrement qualifier while running
//   stop         abort countdown, count held
//   auto_reload  sampled at terminal count: 1 = restart from reload register, 0 = stop
//   count        current count (registered)
//   busy         high while running (registered)
//   done         one-cycle pulse on terminal count (registered)
module down_timer
    import down_timer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;

    // Priority: load > stop > decrement.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = (load_value != CNT_ZERO) ? ST_RUN : ST_IDLE;
        end else if (stop) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_RUN && enable) begin
            if (count_q == CNT_ONE) begin
                done_d = 1'b1;
                if (auto_reload) begin
                    // reload_q is nonzero whenever RUN was entered, so count stays nonzero.
                    count_d = reload_q;
                end else begin
                    count_d = CNT_ZERO;
                    state_d = ST_IDLE;
                end
            end else begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= CNT_ZERO;
            reload_q <= CNT_ZERO;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = done_q;

    // Structural invariants of the countdown.
    a_busy_nonzero : assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_RUN) |-> (count_q != CNT_ZERO));

    a_done_after_one : assert property (@(posedge clk) disable iff (reset)
        done_q |-> ($past(count_q) == CNT_ONE));

    a_hold_when_idle_input : assert property (@(posedge clk) disable iff (reset)
        (!enable && !load) |=> $stable(count_q));

endmodule : down_timer
